// File: rtl/tim6_counter.sv
// TIM6 counting core: shadowed prescaler, 16-bit up-counter wrapping at ARR, update event, UIF and OPM stop.
// Optional ARR preload shadow is built when TIM6_ARPE_EN is defined.
module tim6_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_psc,
    input  logic [W-1:0] i_arr,
    input  logic         i_cen,
    input  logic         i_opm,
    input  logic         i_udis,
    input  logic         i_urs,
    input  logic         i_arpe,
    input  logic         i_ug,
    input  logic         i_uif_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_uif,
    output logic         o_uev,
    output logic         o_cen_clr
);

    // WAIT_LOW is the reset state: counting needs i_cen to be seen low before it may start
    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RUN      = 2'd2
    } run_state_t;

    run_state_t   state;
    run_state_t   state_nxt;

    logic [W-1:0] psc_cnt;
    logic [W-1:0] psc_sh;
    logic [W-1:0] cnt;
    logic         uif;
    logic         uev;
    logic         cen_clr;

    logic [W-1:0] arr_act;
    logic         run;
    logic         tick;
    logic         ovf;
    logic         load;
    logic         raise;
    logic         opm_stop;
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] psc_cnt_nxt;

`ifdef TIM6_ARPE_EN
    logic [W-1:0] arr_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_sh <= '0;
        end else if (load) begin
            arr_sh <= i_arr;
        end
    end

    assign arr_act = i_arpe ? arr_sh : i_arr;
`else
    logic unused_arpe;

    assign unused_arpe = i_arpe;
    assign arr_act     = i_arr;
`endif

    assign run = (state == ST_RUN);

    // A software update takes priority over a coincident overflow for UIF/UEV qualification
    always_comb begin
        tick        = run && (psc_cnt == psc_sh);
        ovf         = tick && (arr_act != '0) && (cnt == arr_act);
        load        = (ovf || i_ug) && !i_udis;
        raise       = !i_udis && (i_ug ? !i_urs : ovf);
        opm_stop    = ovf && i_opm;

        psc_cnt_nxt = psc_cnt;
        if (i_ug) begin
            psc_cnt_nxt = '0;
        end else if (run) begin
            psc_cnt_nxt = (psc_cnt == psc_sh) ? '0 : psc_cnt + W'(1);
        end

        cnt_nxt = cnt;
        if (i_ug) begin
            cnt_nxt = '0;
        end else if (tick) begin
            if ((arr_act == '0) || (cnt == arr_act)) begin
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_WAIT_LOW: begin
                if (!i_cen) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (i_cen) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_cen) begin
                    state_nxt = ST_ARMED;
                end else if (opm_stop) begin
                    state_nxt = ST_WAIT_LOW;
                end
            end
            default: begin
                state_nxt = ST_WAIT_LOW;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT_LOW;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt <= '0;
            psc_sh  <= '0;
            cnt     <= '0;
            uif     <= 1'b0;
            uev     <= 1'b0;
            cen_clr <= 1'b0;
        end else begin
            psc_cnt <= psc_cnt_nxt;
            cnt     <= cnt_nxt;
            uev     <= raise;
            cen_clr <= opm_stop;
            if (load) begin
                psc_sh <= i_psc;
            end
            // Set wins over a same-cycle software clear
            if (raise) begin
                uif <= 1'b1;
            end else if (i_uif_clr) begin
                uif <= 1'b0;
            end
        end
    end

    assign o_cnt     = cnt;
    assign o_uif     = uif;
    assign o_uev     = uev;
    assign o_cen_clr = cen_clr;

endmodule

// File: doc/tim6_counter.md
# tim6_counter

Counting core of basic timer TIM6, directly downstream of the TIM6 prescaler and auto-reload registers. It takes the programmed prescaler value and auto-reload value, keeps shadow copies that change only on an update event, and divides `clk` by (PSC+1). It runs a 16-bit up-counter that wraps at ARR, and produces the update event, the UIF status flag and the one-pulse-mode enable clear back to the control register.

## Interface
Parameters:
- `W`, 16, width of the prescaler, counter and auto-reload paths.

Ports:
- `clk`  in  1  timer kernel clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low; one clock domain only.
- `i_psc`  in  W  programmed prescaler value from the PSC register.
- `i_arr`  in  W  programmed auto-reload value from the ARR register.
- `i_cen`  in  1  counter enable level (CR1.CEN).
- `i_opm`  in  1  one-pulse mode (CR1.OPM).
- `i_udis`  in  1  update disable (CR1.UDIS).
- `i_urs`  in  1  update request source (CR1.URS); 1 means only overflow raises UIF and `o_uev`.
- `i_arpe`  in  1  ARR preload enable (CR1.ARPE); used only with `TIM6_ARPE_EN`.
- `i_ug`  in  1  single-cycle software update generation (EGR.UG).
- `i_uif_clr`  in  1  single-cycle UIF clear (SR write-0).
- `o_cnt`  out  W  current counter value (CNT).
- `o_uif`  out  1  update interrupt flag (SR.UIF), level.
- `o_uev`  out  1  single-cycle update event pulse (TRGO / interrupt request source).
- `o_cen_clr`  out  1  single-cycle request to clear CR1.CEN (OPM end).

## Operation
- State: `psc_cnt`, `psc_sh`, `cnt`, `arr_sh` (ARPE only), `run`, `uif`.
- Reset: every register is 0. All outputs are 0. `run` is 0.
- `run` flag:
  - Set on the first cycle `i_cen`=1 while `run`=0 and no OPM stop is pending.
  - Cleared when `i_cen`=0, or on an OPM overflow.
  - After an OPM stop, `run` stays 0 until `i_cen` has been seen low.
- Prescaler:
  - While `run`=1, `psc_cnt` increments.
  - When `psc_cnt`==`psc_sh`, `psc_cnt` returns to 0 and a counter tick is produced.
  - Tick rate is `clk`/(`psc_sh`+1). With `psc_sh`=0 there is a tick every cycle.
- Counter:
  - On a tick, if `cnt`==`arr_act` then `cnt` becomes 0 (overflow); otherwise `cnt` becomes `cnt`+1.
  - With `arr_act`==0 the counter holds 0, no overflow occurs, and the prescaler keeps running.
  - `arr_act` is `arr_sh` when preload is active, and `i_arr` otherwise.
- Update event (UEV):
  - Sources are overflow and `i_ug`.
  - `i_ug` always clears `cnt` and `psc_cnt`, regardless of `run` and `i_udis`.
  - On UEV with `i_udis`=0: `psc_sh`<=`i_psc` and `arr_sh`<=`i_arr`.
  - Shadow loads, `uif` set and `o_uev` are suppressed when `i_udis`=1. The counter still wraps on overflow.
  - `uif` set and `o_uev` pulse on UEV when `i_udis`=0, except when the source is `i_ug` with `i_urs`=1: in that case the shadows load but `uif` and `o_uev` are not raised.
- OPM: an overflow with `i_opm`=1 clears `run` and pulses `o_cen_clr`, even with `i_udis`=1. `cnt` rests at 0.
- UIF: `i_uif_clr` clears `uif`. If set and clear occur in the same cycle, set wins.
- Overlap: if `i_ug` coincides with an overflow, a single UEV is produced and `i_ug` rules apply.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Overflow edge: on the edge where `cnt` goes `arr_act`->0, `o_uev`, `uif` and `o_cen_clr` are all asserted in that same edge. `o_uev` and `o_cen_clr` drop after one cycle.
- `i_ug` sampled at edge N: `cnt`=0, shadows loaded and `o_uev` high after edge N.
- Enable: `i_cen` rising seen at edge N sets `run` at N. The first `psc_cnt` increment is at edge N+1, and the first `cnt` increment at edge N+1+`psc_sh`.
- `i_psc` changes take effect only after the next UEV. The current period always completes with the old divisor.
- Asynchronous reset mid-count returns every register to 0 immediately. After release, a `i_cen` rising edge is required before counting starts.

## Configuration
- Macro: `TIM6_ARPE_EN`.
- Defined: `arr_sh` exists. With `i_arpe`=1, `arr_act`=`arr_sh`, loaded only on UEV. With `i_arpe`=0, `arr_act`=`i_arr`.
- Undefined: `arr_sh` and `i_arpe` logic are removed. The `i_arpe` port remains but is ignored, and `arr_act`=`i_arr` always.

## Test plan
- Prescaler and period: `i_psc`=2, `i_arr`=4, pulse `i_ug`, then `i_cen`=1 -> `cnt` steps every 3 cycles through 0..4; `o_uev` pulses every 15 cycles; `o_uif`=1 after the first wrap.
- PSC shadowing: while counting with PSC=2, write `i_psc`=0 mid-period -> the current period stays at 15 cycles, then the period becomes 5 cycles.
- One-pulse mode: `i_opm`=1, ARR=3, PSC=0, `i_cen`=1 -> exactly one wrap; `o_cen_clr` pulses once; `cnt` stays 0 while `i_cen` remains high.
- UG with URS and UDIS:
  - `i_urs`=1 plus `i_ug` -> `cnt`=0, shadows load, no `o_uev`, `o_uif` stays 0.
  - `i_udis`=1 plus `i_ug` -> `cnt`=0, shadows unchanged.
- UIF race: `i_uif_clr` in the same cycle as an overflow -> `o_uif`=1. The next isolated `i_uif_clr` -> `o_uif`=0.
- ARPE (with `TIM6_ARPE_EN`): `i_arpe`=1, ARR 9->2 written at `cnt`=5 -> the counter reaches 9 before wrapping, then wraps at 2. With `i_arpe`=0, the same write at `cnt`=5 makes the counter run up to 0xFFFF, then wrap at 2.
